broadcast_pipe: RTL and testbench
=================================

// Module: broadcast_pipe
// PURPOSE
//  Registered, handshaked successor of the combinational tile broadcaster.
//  - Expands vector/matrix operands into ROWS x COLS A/B tiles for the PE array (MAC/EWM/EWA modes).
//  - Adds: a valid/ready pipeline stage; a held B vector reused across tiles;
//    illegal-mode detection; a per-vector tile counter.
//  - Sits between the operand fetch/scratchpad and the PE array input registers.
// PARAMETERS
//  ROWS       4   tile rows (i index)
//  COLS       4   tile columns (j index)
//  DATA_WIDTH 16  signed element width
//  VLEN       max(ROWS,COLS)  b_vec length (derived localparam, not overridable)
//  CNT_W      8   tile_cnt width
// PORTS
//  clk          in   1                    clock; all logic on posedge
//  rst          in   1                    synchronous, active-high reset
//  in_valid     in   1                    input beat valid
//  in_ready     out  1                    block can accept a beat
//  mode         in   3                    bcast_mode_e, sampled with the beat
//  b_vec_load   in   1                    1: capture b_vec into hold reg and use it; 0: use held vector
//  a_vec        in   ROWS*DATA_WIDTH      signed vector operand A
//  b_vec        in   VLEN*DATA_WIDTH      signed vector operand B
//  a_mat        in   ROWS*COLS*DATA_WIDTH matrix / multi-vector operand A
//  b_mat        in   ROWS*COLS*DATA_WIDTH matrix / multi-vector operand B
//  out_valid    out  1                    tile valid
//  out_ready    in   1                    PE array accepts tile
//  a_tile       out  ROWS*COLS*DATA_WIDTH A tile to array
//  b_tile       out  ROWS*COLS*DATA_WIDTH B tile to array
//  out_mode     out  3                    mode travelling with the tile
//  tile_cnt     out  CNT_W                tiles emitted since last b_vec_load
//  err_mode     out  1                    sticky illegal-mode flag
// BEHAVIOUR
//  - Reset (rst=1 at posedge): out_valid=0, a_tile/b_tile=0, out_mode=0, b_hold=0, tile_cnt=0,
//    err_mode=0. A beat in the output register is discarded. in_ready=1 the cycle after reset.
//  - Handshake: in_ready = !out_valid || out_ready (combinational). Accept when in_valid&&in_ready.
//    Outputs hold stable while out_valid&&!out_ready. Latency 1 cycle; 1 beat/cycle sustained.
//  - Vector source: bv = b_vec_load ? b_vec : b_hold. On accept with b_vec_load=1, b_hold<=b_vec.
//  - Mode map (i row, j col):
//      000 MAC:      A=a_mat,   B[i][j]=bv[j]
//      001 EWM-Mat:  A=a_mat,   B[i][j]=bv[i]
//      010/100:      A=a_mat,   B=b_mat
//      011 Outer:    A[i][j]=a_vec[i], B[i][j]=bv[j]
//      101/110:      A=a_mat,   B=b_mat
//      111 illegal:  both tiles 0, beat still emitted, err_mode<=1 (cleared only by rst)
//  - Elements copied bit-exact; no arithmetic, no sign extension.
//  - tile_cnt: on accept, <= b_vec_load ? 1 : tile_cnt+1; wraps 2^CNT_W-1 -> 0 silently.
//    Counts every accepted beat regardless of mode.
//  - Back-to-back: accept in the same cycle the held tile drains (out_ready=1) replaces it, out_valid stays 1.
//  - Indices VLEN-1 beyond COLS (mode 000/011) or ROWS (001) are ignored.
// STRUCTURE
//  - bcast_pkg: bcast_mode_e enum (MAC, EWM_MAT, EWM_VEC, OUTER, EWA_VEC, EWA_MAT, EWM_MAT2, ILLEGAL),
//    tile/vector typedefs parameterised by ROWS/COLS/DATA_WIDTH.
//  - Sub-module bcast_xbar: combinational mode map (mode, a_vec, bv, a_mat, b_mat -> tiles, illegal).
//  - Top: hold register, tile counter, pipeline register, handshake.
// TESTING (ROWS=COLS=4, DATA_WIDTH=16 unless noted)
//  1 MAC: a_mat[i][j]=16*i+j, b_vec={4,3,2,1}, load=1 -> 1 cycle later out_valid, B row i = {4,3,2,1} for every i,
//    A==a_mat, tile_cnt=1.
//  2 Reuse: load b_vec={-1,2,-3,4}, then 3 beats load=0 with b_vec=0xAAAA -> all B use {-1,2,-3,4}, tile_cnt 1,2,3,4.
//  3 Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 from cycle 2, tile unchanged, no beat lost;
//    release -> beats emitted in order.
//  4 Outer, ROWS=2 COLS=8: a_vec={7,-8}, b_vec=0..7 -> A[i][j]=a_vec[i], B[i][j]=j; mode 001 ROWS=8 COLS=2 B[i][j]=bv[i].
//  5 Illegal mode 111 -> zero tiles emitted, err_mode=1 and stays 1 after legal beats; rst clears it.
//  6 Reset mid-stream: rst=1 while out_valid=1, out_ready=0 -> next cycle out_valid=0, tile_cnt=0, b_hold=0;
//    CNT_W=2 wrap 3->0.

Source files
------------

// File: rtl/bcast_pkg.sv
// Shared types for the tile broadcaster: operand-expansion modes and default-geometry
// element/vector/tile types.
package bcast_pkg;

  typedef enum logic [2:0] {
    ModeMac     = 3'd0,
    ModeEwmMat  = 3'd1,
    ModeEwmVec  = 3'd2,
    ModeOuter   = 3'd3,
    ModeEwaVec  = 3'd4,
    ModeEwaMat  = 3'd5,
    ModeEwmMat2 = 3'd6,
    ModeIllegal = 3'd7
  } bcast_mode_e;

  localparam int unsigned DefRows      = 4;
  localparam int unsigned DefCols      = 4;
  localparam int unsigned DefDataWidth = 16;

  typedef logic [DefDataWidth-1:0]                 elem_t;
  typedef logic [DefRows*DefDataWidth-1:0]         vec_t;
  typedef logic [DefRows*DefCols*DefDataWidth-1:0] tile_t;

  // The B vector must cover whichever tile dimension it is broadcast along.
  function automatic int unsigned vlen_of(input int unsigned rows, input int unsigned cols);
    return (rows > cols) ? rows : cols;
  endfunction

endpackage

// File: rtl/bcast_xbar.sv
// Combinational operand crossbar: expands vector/matrix operands into A/B tiles
// according to the broadcast mode. Elements are copied bit-exact.
module bcast_xbar
  import bcast_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned VLEN       = 4
) (
  input  logic [2:0]                     mode_i,
  input  logic [ROWS*DATA_WIDTH-1:0]      a_vec_i,
  input  logic [VLEN*DATA_WIDTH-1:0]      bv_i,
  input  logic [ROWS*COLS*DATA_WIDTH-1:0] a_mat_i,
  input  logic [ROWS*COLS*DATA_WIDTH-1:0] b_mat_i,
  output logic [ROWS*COLS*DATA_WIDTH-1:0] a_tile_o,
  output logic [ROWS*COLS*DATA_WIDTH-1:0] b_tile_o,
  output logic                            illegal_o
);

  localparam int unsigned DW = DATA_WIDTH;

  bcast_mode_e mode_e;
  assign mode_e = bcast_mode_e'(mode_i);

  always_comb begin
    a_tile_o  = a_mat_i;
    b_tile_o  = b_mat_i;
    illegal_o = 1'b0;
    case (mode_e)
      ModeMac: begin
        for (int unsigned i = 0; i < ROWS; i++) begin
          for (int unsigned j = 0; j < COLS; j++) begin
            b_tile_o[(i*COLS+j)*DW +: DW] = bv_i[j*DW +: DW];
          end
        end
      end
      ModeEwmMat: begin
        for (int unsigned i = 0; i < ROWS; i++) begin
          for (int unsigned j = 0; j < COLS; j++) begin
            b_tile_o[(i*COLS+j)*DW +: DW] = bv_i[i*DW +: DW];
          end
        end
      end
      ModeOuter: begin
        for (int unsigned i = 0; i < ROWS; i++) begin
          for (int unsigned j = 0; j < COLS; j++) begin
            a_tile_o[(i*COLS+j)*DW +: DW] = a_vec_i[i*DW +: DW];
            b_tile_o[(i*COLS+j)*DW +: DW] = bv_i[j*DW +: DW];
          end
        end
      end
      ModeIllegal: begin
        a_tile_o  = '0;
        b_tile_o  = '0;
        illegal_o = 1'b1;
      end
      default: ;  // remaining modes pass both matrices straight through
    endcase
  end

endmodule

// File: rtl/broadcast_pipe.sv
// Registered, valid/ready tile broadcaster: holds a reusable B vector, counts tiles per
// loaded vector and flags illegal modes sticky until reset.
module broadcast_pipe
  import bcast_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [2:0]                                    mode,
  input  logic                                          b_vec_load,
  input  logic [ROWS*DATA_WIDTH-1:0]                    a_vec,
  input  logic [vlen_of(ROWS, COLS)*DATA_WIDTH-1:0]     b_vec,
  input  logic [ROWS*COLS*DATA_WIDTH-1:0]               a_mat,
  input  logic [ROWS*COLS*DATA_WIDTH-1:0]               b_mat,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [ROWS*COLS*DATA_WIDTH-1:0]               a_tile,
  output logic [ROWS*COLS*DATA_WIDTH-1:0]               b_tile,
  output logic [2:0]                                    out_mode,
  output logic [CNT_W-1:0]                              tile_cnt,
  output logic                                          err_mode
);

  localparam int unsigned VLEN = vlen_of(ROWS, COLS);
  localparam int unsigned TW   = ROWS * COLS * DATA_WIDTH;

  logic                       out_valid_q;
  logic [TW-1:0]              a_tile_q, b_tile_q;
  logic [2:0]                 out_mode_q;
  logic [CNT_W-1:0]           tile_cnt_q, tile_cnt_d;
  logic                       err_mode_q;
  logic [VLEN*DATA_WIDTH-1:0] b_hold_q;

  logic [VLEN*DATA_WIDTH-1:0] bv;
  logic [TW-1:0]              a_tile_d, b_tile_d;
  logic                       illegal;
  logic                       accept;

  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign bv         = b_vec_load ? b_vec : b_hold_q;
  assign tile_cnt_d = b_vec_load ? CNT_W'(1) : tile_cnt_q + CNT_W'(1);

  bcast_xbar #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .DATA_WIDTH (DATA_WIDTH),
    .VLEN       (VLEN)
  ) u_xbar (
    .mode_i    (mode),
    .a_vec_i   (a_vec),
    .bv_i      (bv),
    .a_mat_i   (a_mat),
    .b_mat_i   (b_mat),
    .a_tile_o  (a_tile_d),
    .b_tile_o  (b_tile_d),
    .illegal_o (illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      a_tile_q    <= '0;
      b_tile_q    <= '0;
      out_mode_q  <= '0;
      tile_cnt_q  <= '0;
      err_mode_q  <= 1'b0;
      b_hold_q    <= '0;
    end else if (accept) begin
      // A new beat replaces the held tile even when it drains in this same cycle.
      out_valid_q <= 1'b1;
      a_tile_q    <= a_tile_d;
      b_tile_q    <= b_tile_d;
      out_mode_q  <= mode;
      tile_cnt_q  <= tile_cnt_d;
      if (b_vec_load) b_hold_q <= b_vec;
      if (illegal) err_mode_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign a_tile    = a_tile_q;
  assign b_tile    = b_tile_q;
  assign out_mode  = out_mode_q;
  assign tile_cnt  = tile_cnt_q;
  assign err_mode  = err_mode_q;

endmodule

// File: tb/tb_broadcast_pipe.sv
// Scoreboard bench for broadcast_pipe: a driver pushes hand-computed expected tiles on
// accept, a monitor pops and compares on every output handshake.
module tb_broadcast_pipe;

  typedef logic [255:0] tile_t;
  typedef logic [63:0]  vec_t;

  typedef struct packed {
    tile_t      a;
    tile_t      b;
    logic [2:0] mode;
    logic [7:0] cnt;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main 4x4 instance
  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [2:0] mode = '0, out_mode;
  logic       b_vec_load = 1'b0, err_mode;
  vec_t       a_vec = '0, b_vec = '0;
  tile_t      a_mat = '0, b_mat = '0, a_tile, b_tile;
  logic [7:0] tile_cnt;

  broadcast_pipe #(.ROWS(4), .COLS(4), .DATA_WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .b_vec_load(b_vec_load), .a_vec(a_vec), .b_vec(b_vec), .a_mat(a_mat), .b_mat(b_mat),
    .out_valid(out_valid), .out_ready(out_ready), .a_tile(a_tile), .b_tile(b_tile),
    .out_mode(out_mode), .tile_cnt(tile_cnt), .err_mode(err_mode)
  );

  // Non-square instances share stimulus; output handshake tied ready
  logic         s_valid = 1'b0, s_one = 1'b1;
  logic [2:0]   s_mode = '0;
  logic [31:0]  a28 = '0;
  logic [127:0] a82 = '0, s_bvec = '0;
  tile_t        s_amat = '0, s_bmat = '0;
  logic         r28, v28, e28, r82, v82, e82;
  logic [2:0]   m28, m82;
  logic [7:0]   c28, c82;
  tile_t        at28, bt28, at82, bt82;

  broadcast_pipe #(.ROWS(2), .COLS(8), .DATA_WIDTH(16), .CNT_W(8)) dut28 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(r28), .mode(s_mode),
    .b_vec_load(s_one), .a_vec(a28), .b_vec(s_bvec), .a_mat(s_amat), .b_mat(s_bmat),
    .out_valid(v28), .out_ready(s_one), .a_tile(at28), .b_tile(bt28),
    .out_mode(m28), .tile_cnt(c28), .err_mode(e28)
  );

  broadcast_pipe #(.ROWS(8), .COLS(2), .DATA_WIDTH(16), .CNT_W(8)) dut82 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(r82), .mode(s_mode),
    .b_vec_load(s_one), .a_vec(a82), .b_vec(s_bvec), .a_mat(s_amat), .b_mat(s_bmat),
    .out_valid(v82), .out_ready(s_one), .a_tile(at82), .b_tile(bt82),
    .out_mode(m82), .tile_cnt(c82), .err_mode(e82)
  );

  // 2-bit counter instance for wrap
  logic       c_valid = 1'b0, c_load = 1'b0, rc, vc, ec;
  logic [2:0] mc;
  logic [1:0] cc;
  tile_t      atc, btc;

  broadcast_pipe #(.ROWS(4), .COLS(4), .DATA_WIDTH(16), .CNT_W(2)) dutc (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(rc), .mode(mode),
    .b_vec_load(c_load), .a_vec(a_vec), .b_vec(b_vec), .a_mat(a_mat), .b_mat(b_mat),
    .out_valid(vc), .out_ready(s_one), .a_tile(atc), .b_tile(btc),
    .out_mode(mc), .tile_cnt(cc), .err_mode(ec)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_err = 1'b0;
  exp_t sb[$];
  exp_t got_e;

  task automatic chk(input string name, input tile_t got, input tile_t want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got a_tile %h required no beat", a_tile);
      end else begin
        got_e = sb.pop_front();
        chk("a_tile", a_tile, got_e.a);
        chk("b_tile", b_tile, got_e.b);
        chk("out_mode", tile_t'(out_mode), tile_t'(got_e.mode));
        chk("tile_cnt", tile_t'(tile_cnt), tile_t'(got_e.cnt));
        chk("err_mode", tile_t'(err_mode), tile_t'(got_e.err));
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the beat is taken.
  task automatic send(input logic [2:0] m, input logic ld, input vec_t av, input vec_t bv,
                      input tile_t am, input tile_t bm, input tile_t ea, input tile_t eb,
                      input logic [7:0] ec);
    int waited = 0;
    mode = m; b_vec_load = ld; a_vec = av; b_vec = bv; a_mat = am; b_mat = bm;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready %b required 1", in_ready);
    end else begin
      if (m == 3'b111) exp_err = 1'b1;
      sb.push_back('{a: ea, b: eb, mode: m, cnt: ec, err: exp_err});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending beats required 0", sb.size());
    end
  endtask

  tile_t ramp, bm, b82;
  vec_t  v4321, v2, vaa, av;

  initial begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) ramp[(i*4+j)*16 +: 16] = 16'(16*i + j);
    v4321 = {16'd4, 16'd3, 16'd2, 16'd1};
    v2    = {16'hFFFF, 16'd2, 16'hFFFD, 16'd4};  // {-1,2,-3,4}
    vaa   = {4{16'hAAAA}};
    bm    = ramp ^ {16{16'h5A5A}};
    av    = {16'd40, 16'd30, 16'd20, 16'd10};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", tile_t'(out_valid), '0);
    chk("rst_in_ready", tile_t'(in_ready), tile_t'(1));
    chk("rst_tile_cnt", tile_t'(tile_cnt), '0);
    chk("rst_err_mode", tile_t'(err_mode), '0);
    chk("rst_a_tile", a_tile, '0);
    @(posedge clk);
    #1;

    // MAC with load, then B-vector reuse
    send(3'd0, 1'b1, '0, v4321, ramp, '0, ramp, {4{v4321}}, 8'd1);
    send(3'd0, 1'b1, '0, v2, ramp, '0, ramp, {4{v2}}, 8'd1);
    send(3'd0, 1'b0, '0, vaa, ~ramp, '0, ~ramp, {4{v2}}, 8'd2);
    send(3'd0, 1'b0, '0, vaa, ~ramp, '0, ~ramp, {4{v2}}, 8'd3);
    send(3'd0, 1'b0, '0, vaa, ~ramp, '0, ~ramp, {4{v2}}, 8'd4);
    // Remaining legal modes on the held vector
    send(3'd1, 1'b0, av, vaa, ramp, bm, ramp,
         {{4{16'hFFFF}}, {4{16'h0002}}, {4{16'hFFFD}}, {4{16'h0004}}}, 8'd5);
    send(3'd2, 1'b0, av, vaa, ramp, bm, ramp, bm, 8'd6);
    send(3'd3, 1'b0, av, vaa, ramp, bm,
         {{4{16'd40}}, {4{16'd30}}, {4{16'd20}}, {4{16'd10}}}, {4{v2}}, 8'd7);
    send(3'd4, 1'b0, av, vaa, ramp, bm, ramp, bm, 8'd8);
    send(3'd5, 1'b0, av, vaa, ramp, bm, ramp, bm, 8'd9);
    send(3'd6, 1'b0, av, vaa, ramp, bm, ramp, bm, 8'd10);
    // Illegal mode, then a legal beat with the flag still set
    send(3'd7, 1'b0, av, vaa, ramp, bm, '0, '0, 8'd11);
    send(3'd0, 1'b1, av, v4321, ramp, bm, ramp, {4{v4321}}, 8'd1);
    drain();

    // Backpressure: second beat stalls, first tile holds
    out_ready = 1'b0;
    send(3'd2, 1'b0, '0, vaa, ramp, bm, ramp, bm, 8'd2);
    fork
      send(3'd0, 1'b0, '0, vaa, ~ramp, bm, ~ramp, {4{v4321}}, 8'd3);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_in_ready", tile_t'(in_ready), '0);
          chk("bp_a_hold", a_tile, ramp);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with a stalled beat in the output register
    out_ready = 1'b0;
    send(3'd0, 1'b1, '0, v2, ramp, bm, ramp, {4{v2}}, 8'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    exp_err = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", tile_t'(out_valid), '0);
    chk("mid_rst_tile_cnt", tile_t'(tile_cnt), '0);
    chk("mid_rst_err_mode", tile_t'(err_mode), '0);
    chk("mid_rst_b_tile", b_tile, '0);
    chk("mid_rst_in_ready", tile_t'(in_ready), tile_t'(1));
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(3'd0, 1'b0, '0, vaa, ramp, bm, ramp, '0, 8'd1);  // cleared hold vector
    drain();

    // Non-square geometries
    for (int k = 0; k < 8; k++) s_bvec[k*16 +: 16] = 16'(k);
    a28    = {16'hFFF8, 16'd7};  // {7,-8}
    s_amat = ramp;
    s_mode = 3'd3;
    s_valid = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    chk("outer28_a", at28, {{8{16'hFFF8}}, {8{16'h0007}}});
    chk("outer28_b", bt28, {s_bvec, s_bvec});
    @(posedge clk);
    #1 s_mode = 3'd1;
    s_valid = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) b82[i*32 +: 32] = {16'(i), 16'(i)};
    chk("ewm82_b", bt82, b82);
    chk("ewm82_a", at82, ramp);
    @(posedge clk);
    #1 s_mode = 3'd0;
    s_valid = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    chk("mac82_b", bt82, {8{16'd1, 16'd0}});

    // 2-bit tile counter wrap
    @(posedge clk);
    #1 c_load = 1'b1;
    c_valid = 1'b1;
    @(posedge clk);
    #1 c_load = 1'b0;
    @(negedge clk);
    chk("cnt2_load", tile_t'(cc), tile_t'(1));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("cnt2_two", tile_t'(cc), tile_t'(2));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("cnt2_three", tile_t'(cc), tile_t'(3));
    @(posedge clk);
    #1 c_valid = 1'b0;
    @(negedge clk);
    chk("cnt2_wrap", tile_t'(cc), '0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
